// File: rtl/branch_ctrl.sv
// Branch control for the program counter: decodes the current instruction,
// checks the branch condition against registered ALU flags, looks up the
// jump offset in a programmable table and raises a sticky halt request.
module branch_ctrl #(
    parameter int unsigned LUT_DEPTH = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         CLK,
    input  logic                         init_n,
    input  logic                         instr_valid,
    input  logic [8:0]                   instr,
    input  logic                         alu_zero,
    input  logic                         alu_neg,
    input  logic                         flag_we,
    input  logic                         lut_we,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_addr,
    input  logic [8:0]                   lut_data,
    output logic                         BranchEnable,
    output logic                         BranchTaken,
    output logic                         JumpDirection,
    output logic [7:0]                   JumpAmount,
    output logic                         halt_req,
    output logic [CNT_W-1:0]             taken_count
);

    localparam int unsigned IDX_W  = $clog2(LUT_DEPTH);
    localparam int unsigned ENT_W  = 9;
    localparam logic [8:0]  HALT_OP = 9'b110_111111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   zero_q;
    logic                   neg_q;
    logic [ENT_W-1:0]       lut_q [LUT_DEPTH];
    logic [CNT_W-1:0]       cnt_q;
    logic                   cnt_inc;

    logic                   is_branch;
    logic                   is_halt;
    logic [1:0]             cond;
    logic [IDX_W-1:0]       idx;
    logic                   cond_true;
    logic [ENT_W-1:0]       lut_rd;

    assign is_branch = (instr[8:6] == 3'b111);
    assign is_halt   = (instr == HALT_OP);
    assign cond      = instr[5:4];
    assign idx       = instr[IDX_W-1:0];
    assign lut_rd    = lut_q[idx];

    // Branch condition against the registered flags (no same-cycle bypass)
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = zero_q;
            2'b10:   cond_true = ~zero_q;
            default: cond_true = neg_q;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!init_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and combinational branch outputs; everything is zero in reset
    always_comb begin
        state_d       = state_q;
        BranchEnable  = 1'b0;
        BranchTaken   = 1'b0;
        JumpDirection = 1'b0;
        JumpAmount    = 8'h00;
        cnt_inc       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (instr_valid && is_branch) begin
                    BranchEnable  = 1'b1;
                    BranchTaken   = cond_true;
                    JumpDirection = lut_rd[8];
                    JumpAmount    = lut_rd[7:0];
                    if (cond_true) begin
                        state_d = ST_SQUASH;
                        cnt_inc = 1'b1;
                    end
                end else if (instr_valid && is_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_SQUASH: begin
                state_d = ST_RUN;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (!init_n) begin
            BranchEnable  = 1'b0;
            BranchTaken   = 1'b0;
            JumpDirection = 1'b0;
            JumpAmount    = 8'h00;
            cnt_inc       = 1'b0;
        end
    end

    // ALU flag register
    always_ff @(posedge CLK) begin
        if (!init_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (flag_we) begin
            zero_q <= alu_zero;
            neg_q  <= alu_neg;
        end
    end

    // Jump-offset table; a same-cycle read sees the old entry
    always_ff @(posedge CLK) begin
        if (!init_n) begin
            for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            lut_q[lut_addr] <= lut_data;
        end
    end

    // Saturating taken-branch counter
    always_ff @(posedge CLK) begin
        if (!init_n) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign halt_req    = (state_q == ST_HALTED) && init_n;
    assign taken_count = init_n ? cnt_q : '0;

endmodule
